seg_scan_reader: RTL and testbench
==================================

SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 2..255.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 A, B, C, D, E, F, G  input  1 each  segment lines, active-high, A=MSB of 7-bit code {A,B,C,D,E,F,G}.
REQ-005 DigSel  input  4  digit enable, active-high, expected one-hot; bit k selects digit k.
REQ-006 Digit0, Digit1, Digit2, Digit3  output  4 each  last decoded hex value per digit (registered).
REQ-007 DigValid  output  4  bit k=1 when Digitk holds a valid decode.
REQ-008 Update  output  1  one-cycle pulse on each successful capture.
REQ-009 CodeErr  output  1  one-cycle pulse when a stable pattern is not a legal code.
REQ-010 SelErr  output  1  one-cycle pulse on the first registered sample of a multi-hot DigSel run.
REQ-011 FrameDone  output  1  one-cycle pulse when digit 3 is captured and digits 0..2 were all captured since the previous FrameDone or reset.

Function
REQ-012 Segment and DigSel inputs SHALL be registered once (sample register) before any comparison; all outputs SHALL be registered.
REQ-013 Legal codes (hex: {A..G}): 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000, 8:1111111, 9:1110011, A:1110111, B:0011111, C:1001110, D:0111101, E:1001111, F:1000111; all other 112 codes illegal.
REQ-014 FSM states: IDLE, COUNT, HELD.
REQ-015 IDLE: sample DigSel one-hot -> COUNT, counter=1; otherwise stay.
REQ-016 COUNT: sample differs from previous sample (segments or DigSel) -> counter=1 if new DigSel one-hot (stay COUNT), else IDLE; identical -> counter+1; when counter+1 == STABLE_CYCLES -> capture, go HELD.
REQ-017 HELD: stay while sample identical; any change -> behave as IDLE evaluating the new sample (COUNT with counter=1 if one-hot, else IDLE); no second capture of an unchanged run.
REQ-018 Capture, legal code: Digitk=decoded value, DigValid[k]=1, Update=1 for one cycle.
REQ-019 Capture, illegal code: Digitk unchanged, DigValid[k]=0, CodeErr=1 for one cycle.
REQ-020 Latency: inputs held stable from before edge n through edge n+STABLE_CYCLES-1 SHALL produce capture outputs visible after edge n+STABLE_CYCLES.
REQ-021 DigSel all-zero: FSM to IDLE, no error; multi-hot: FSM to IDLE, SelErr pulse once per run.
REQ-022 Counter width 8 bits; SHALL never wrap (HELD blocks further counting).
REQ-023 Frame tracking: 4-bit seen mask set per successful capture; FrameDone pulses on successful digit-3 capture with mask[2:0]=111, then mask cleared; CodeErr on any digit clears that digit's mask bit.
REQ-024 Update and FrameDone MAY assert in the same cycle; Update and CodeErr SHALL be mutually exclusive.

Reset
REQ-025 Reset=1 at an edge: FSM=IDLE, counter=0, sample register=0, seen mask=0, Digit0..3=0, DigValid=0000, Update=CodeErr=SelErr=FrameDone=0.
REQ-026 Reset SHALL take priority over all other events, including a capture due in the same cycle; reset mid-COUNT discards the run.

Verification
REQ-027 Hold {A..G}=1101101, DigSel=0100 for 4 edges (STABLE_CYCLES=4) -> after 5th edge Digit2=2, DigValid=0100, Update pulses once; holding longer gives no further Update.
REQ-028 Hold 1101101/DigSel=0100 for 3 edges then change to 1111001 -> no capture; counter restarts; 4 more stable edges -> Digit2=3.
REQ-029 Hold illegal 0000001 on DigSel=0001 for 4 edges -> CodeErr pulse, DigValid[0]=0, Digit0 unchanged.
REQ-030 DigSel=0011 for 6 edges -> exactly one SelErr pulse, no capture; DigSel=0000 -> no pulses.
REQ-031 Scan codes 0, 1, 2, 3 on DigSel 0001, 0010, 0100, 1000, each 4 stable edges -> Digit0..3=0,1,2,3, DigValid=1111, FrameDone pulses with digit-3 Update.
REQ-032 Assert Reset on the edge a capture is due -> all outputs 0, no Update pulse.

Source files
------------

// File: rtl/seg_scan_reader.sv
// Recovers hex digits from a multiplexed 7-segment display scan. Each captured
// digit must be stable for STABLE_CYCLES samples; code, select and frame status are reported as pulses.
module seg_scan_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic [3:0] DigSel,
    output logic [3:0] Digit0,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [3:0] Digit3,
    output logic [3:0] DigValid,
    output logic       Update,
    output logic       CodeErr,
    output logic       SelErr,
    output logic       FrameDone
);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [6:0] seg_q, seg_prev_q;
    logic [3:0] sel_q, sel_prev_q;
    logic [3:0] seen_q;
    logic [3:0] digit_q [4];
    logic [3:0] valid_q;
    logic       upd_q, cerr_q, serr_q, fd_q;

    logic       samp_chg, sel_1h, sel_multi, capture, code_ok, run_start;
    logic [3:0] code_val;
    logic [1:0] dig_idx;
    logic [7:0] cnt_inc;

    always_comb begin
        samp_chg  = {seg_q, sel_q} != {seg_prev_q, sel_prev_q};
        sel_1h    = $onehot(sel_q);
        sel_multi = (sel_q != 4'd0) && !sel_1h;
        cnt_inc   = cnt_q + 8'd1;
        capture   = (state_q == COUNT) && !samp_chg && (cnt_inc == STABLE_CNT);
        // Anything other than a live COUNT/HELD run re-evaluates the sample from scratch.
        run_start = samp_chg || ((state_q != COUNT) && (state_q != HELD));

        dig_idx = 2'd0;
        case (sel_q)
            4'b0010: dig_idx = 2'd1;
            4'b0100: dig_idx = 2'd2;
            4'b1000: dig_idx = 2'd3;
            default: dig_idx = 2'd0;
        endcase

        code_ok  = 1'b1;
        code_val = 4'h0;
        case (seg_q)
            7'b1111110: code_val = 4'h0;
            7'b0110000: code_val = 4'h1;
            7'b1101101: code_val = 4'h2;
            7'b1111001: code_val = 4'h3;
            7'b0110011: code_val = 4'h4;
            7'b1011011: code_val = 4'h5;
            7'b1011111: code_val = 4'h6;
            7'b1110000: code_val = 4'h7;
            7'b1111111: code_val = 4'h8;
            7'b1110011: code_val = 4'h9;
            7'b1110111: code_val = 4'hA;
            7'b0011111: code_val = 4'hB;
            7'b1001110: code_val = 4'hC;
            7'b0111101: code_val = 4'hD;
            7'b1001111: code_val = 4'hE;
            7'b1000111: code_val = 4'hF;
            default:    code_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            seg_q      <= 7'd0;
            sel_q      <= 4'd0;
            seg_prev_q <= 7'd0;
            sel_prev_q <= 4'd0;
            seen_q     <= 4'd0;
            for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
            valid_q    <= 4'd0;
            upd_q      <= 1'b0;
            cerr_q     <= 1'b0;
            serr_q     <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            seg_q      <= {A, B, C, D, E, F, G};
            sel_q      <= DigSel;
            seg_prev_q <= seg_q;
            sel_prev_q <= sel_q;
            upd_q      <= 1'b0;
            cerr_q     <= 1'b0;
            fd_q       <= 1'b0;
            serr_q     <= sel_multi && (sel_q != sel_prev_q);

            if (run_start) begin
                state_q <= sel_1h ? COUNT : IDLE;
                cnt_q   <= sel_1h ? 8'd1 : 8'd0;
            end else if (state_q == COUNT) begin
                cnt_q <= cnt_inc;
                if (capture) begin
                    state_q <= HELD;
                    if (code_ok) begin
                        digit_q[dig_idx] <= code_val;
                        valid_q[dig_idx] <= 1'b1;
                        upd_q            <= 1'b1;
                        if (dig_idx == 2'd3 && seen_q[2:0] == 3'b111) begin
                            fd_q   <= 1'b1;
                            seen_q <= 4'd0;
                        end else begin
                            seen_q[dig_idx] <= 1'b1;
                        end
                    end else begin
                        valid_q[dig_idx] <= 1'b0;
                        cerr_q           <= 1'b1;
                        seen_q[dig_idx]  <= 1'b0;
                    end
                end
            end
        end
    end

    assign Digit0    = digit_q[0];
    assign Digit1    = digit_q[1];
    assign Digit2    = digit_q[2];
    assign Digit3    = digit_q[3];
    assign DigValid  = valid_q;
    assign Update    = upd_q;
    assign CodeErr   = cerr_q;
    assign SelErr    = serr_q;
    assign FrameDone = fd_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: a run-length model of the sample stream is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_seg_scan_reader;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'd0;
    logic [3:0] sel_in = 4'd0;
    logic [3:0] Digit0, Digit1, Digit2, Digit3, DigValid;
    logic       Update, CodeErr, SelErr, FrameDone;

    seg_scan_reader #(.STABLE_CYCLES(SC)) dut (
        .Clk(clk), .Reset(rst),
        .A(seg_in[6]), .B(seg_in[5]), .C(seg_in[4]), .D(seg_in[3]),
        .E(seg_in[2]), .F(seg_in[1]), .G(seg_in[0]),
        .DigSel(sel_in),
        .Digit0(Digit0), .Digit1(Digit1), .Digit2(Digit2), .Digit3(Digit3),
        .DigValid(DigValid), .Update(Update), .CodeErr(CodeErr),
        .SelErr(SelErr), .FrameDone(FrameDone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Display code table, index = hex value
    logic [6:0] codes [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    // Model: each registered sample carries the length of the identical run it ends;
    // a one-hot sample whose run reaches exactly SC is captured on the next edge.
    logic [10:0] m_samp;
    int          m_len;
    logic [3:0]  m_prev_sel;
    logic [3:0]  e_digit [4];
    logic [3:0]  e_valid, e_seen;
    logic        e_upd, e_cerr, e_serr, e_fd;
    bit          model_live = 1'b0;
    logic [10:0] ev;
    int          elen, idx, k;

    always @(posedge clk) begin
        if (rst) begin
            m_samp = '0; m_len = 1; m_prev_sel = '0;
            for (int i = 0; i < 4; i++) e_digit[i] = '0;
            e_valid = '0; e_seen = '0;
            e_upd = 0; e_cerr = 0; e_serr = 0; e_fd = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            ev = m_samp; elen = m_len;
            e_upd = 0; e_cerr = 0; e_fd = 0;
            e_serr = (ev[3:0] != 0) && !$onehot(ev[3:0]) && (ev[3:0] != m_prev_sel);
            if ($onehot(ev[3:0]) && elen == SC) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (ev[i]) k = i;
                idx = lookup(ev[10:4]);
                if (idx >= 0) begin
                    e_digit[k] = idx[3:0];
                    e_valid[k] = 1'b1;
                    e_upd = 1'b1;
                    e_seen[k] = 1'b1;
                    if (k == 3 && e_seen[2:0] == 3'b111) begin
                        e_fd = 1'b1;
                        e_seen = '0;
                    end
                end else begin
                    e_valid[k] = 1'b0;
                    e_cerr = 1'b1;
                    e_seen[k] = 1'b0;
                end
            end
            m_len = ({seg_in, sel_in} == ev) ? elen + 1 : 1;
            m_prev_sel = ev[3:0];
            m_samp = {seg_in, sel_in};
        end
    end

    int upd_cnt = 0, cerr_cnt = 0, serr_cnt = 0, fd_cnt = 0, fd_upd_cnt = 0;

    always @(negedge clk) begin
        if (model_live) begin
            check("digit0", Digit0, e_digit[0]);
            check("digit1", Digit1, e_digit[1]);
            check("digit2", Digit2, e_digit[2]);
            check("digit3", Digit3, e_digit[3]);
            check("digvalid", DigValid, e_valid);
            check("update", Update, e_upd);
            check("codeerr", CodeErr, e_cerr);
            check("selerr", SelErr, e_serr);
            check("framedone", FrameDone, e_fd);
            if (Update) upd_cnt++;
            if (CodeErr) cerr_cnt++;
            if (SelErr) serr_cnt++;
            if (FrameDone) fd_cnt++;
            if (FrameDone && Update) fd_upd_cnt++;
        end
    end

    // Inputs stay put across n rising edges; returns just before the last of them.
    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        repeat (n) begin
            @(negedge clk); #1;
            seg_in = s; sel_in = d;
        end
    endtask

    int u0, c0, s0, f0, fu0;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_update", Update, 1'b0);
        check("rst_digvalid", DigValid, 4'b0000);
        check("rst_digits", {Digit3, Digit2, Digit1, Digit0}, 16'h0000);
        check("rst_pulses", {CodeErr, SelErr, FrameDone}, 3'b000);
        rst = 1'b0;

        // Digit 2 shows "2"; holding longer yields no second capture
        u0 = upd_cnt;
        hold(7'b1101101, 4'b0100, 8);
        hold(7'd0, 4'b0000, 3);
        check("s27_digit2", Digit2, 4'h2);
        check("s27_valid", DigValid, 4'b0100);
        check("s27_updates", upd_cnt - u0, 1);

        // Run broken after 3 edges restarts the count
        u0 = upd_cnt;
        hold(7'b1101101, 4'b0100, 3);
        hold(7'b1111001, 4'b0100, 4);
        hold(7'd0, 4'b0000, 3);
        check("s28_digit2", Digit2, 4'h3);
        check("s28_updates", upd_cnt - u0, 1);

        // Illegal pattern leaves the old digit value but clears its valid bit
        hold(7'b1110000, 4'b0001, 4);
        hold(7'd0, 4'b0000, 3);
        check("s29_pre_digit0", Digit0, 4'h7);
        c0 = cerr_cnt; u0 = upd_cnt;
        hold(7'b0000001, 4'b0001, 4);
        hold(7'd0, 4'b0000, 3);
        check("s29_codeerr", cerr_cnt - c0, 1);
        check("s29_no_update", upd_cnt - u0, 0);
        check("s29_digit0", Digit0, 4'h7);
        check("s29_valid", DigValid, 4'b0100);

        // Multi-hot select: single SelErr, no capture; all-zero: silent
        s0 = serr_cnt; u0 = upd_cnt; c0 = cerr_cnt;
        hold(7'b1101101, 4'b0011, 6);
        hold(7'b1101101, 4'b0000, 6);
        hold(7'd0, 4'b0000, 2);
        check("s30_selerr", serr_cnt - s0, 1);
        check("s30_no_update", upd_cnt - u0, 0);
        check("s30_no_codeerr", cerr_cnt - c0, 0);

        // Full scan of four digits completes a frame
        u0 = upd_cnt; f0 = fd_cnt; fu0 = fd_upd_cnt;
        hold(codes[0], 4'b0001, 4);
        hold(codes[1], 4'b0010, 4);
        hold(codes[2], 4'b0100, 4);
        hold(codes[3], 4'b1000, 4);
        hold(7'd0, 4'b0000, 3);
        check("s31_digits", {Digit3, Digit2, Digit1, Digit0}, 16'h3210);
        check("s31_valid", DigValid, 4'b1111);
        check("s31_updates", upd_cnt - u0, 4);
        check("s31_framedone", fd_cnt - f0, 1);
        check("s31_fd_with_upd", fd_upd_cnt - fu0, 1);

        // Every legal code back-to-back on digit 1
        u0 = upd_cnt;
        for (int i = 0; i < 16; i++) hold(codes[i], 4'b0010, 5);
        hold(7'd0, 4'b0000, 3);
        check("allcodes_updates", upd_cnt - u0, 16);
        check("allcodes_digit1", Digit1, 4'hF);

        // Digit 3 alone after a frame must not raise FrameDone
        f0 = fd_cnt;
        hold(codes[9], 4'b1000, 4);
        hold(7'd0, 4'b0000, 3);
        check("lone_d3_nofd", fd_cnt - f0, 0);
        check("lone_d3_digit3", Digit3, 4'h9);

        // Reset lands on the edge the capture is due
        u0 = upd_cnt;
        hold(codes[5], 4'b0100, 4);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        check("s32_update", Update, 1'b0);
        check("s32_updates", upd_cnt - u0, 0);
        check("s32_valid", DigValid, 4'b0000);
        check("s32_digits", {Digit3, Digit2, Digit1, Digit0}, 16'h0000);
        rst = 1'b0;
        hold(7'd0, 4'b0000, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
